// File: rtl/debounce_bcd7.sv
// Push-button debouncer with press strobe, plus a BCD-to-7-segment decoder (active-low segments).
// Define DEBOUNCE_BCD7_HEX_EN to show hex glyphs A..F for codes 10..15 instead of blanking them.
module debounce_bcd7 #(
  parameter int unsigned STABLE_CYCLES = 2000000,
  parameter int unsigned CNT_WIDTH     = 21
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_i,
  output logic       key_o,
  output logic       key_rise,
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  localparam logic [CNT_WIDTH-1:0] LP_CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] LP_CNT_ONE  = CNT_WIDTH'(1);

  logic [1:0]           r_sync;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_key;
  logic                 r_rise;
  logic                 w_key_s;
  logic                 w_key_next;
  logic [CNT_WIDTH-1:0] w_cnt_next;

  assign w_key_s = r_sync[1];

  // The counter only runs while the synchronized key disagrees with the
  // debounced level; any agreement (a bounce back) restarts it from zero.
  always_comb begin
    w_key_next = r_key;
    w_cnt_next = '0;
    if (w_key_s != r_key) begin
      if (r_cnt == LP_CNT_LAST) begin
        w_key_next = w_key_s;
      end else begin
        w_cnt_next = r_cnt + LP_CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b00;
      r_cnt  <= '0;
      r_key  <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], key_i};
      r_cnt  <= w_cnt_next;
      r_key  <= w_key_next;
      r_rise <= w_key_next & ~r_key;
    end
  end

  assign key_o    = r_key;
  assign key_rise = r_rise;

  // Segment order {g,f,e,d,c,b,a}; a 0 lights the segment.
  always_comb begin
    seg_o = 7'h7F;
    case (bcd_i)
      4'd0:  seg_o = 7'h40;
      4'd1:  seg_o = 7'h79;
      4'd2:  seg_o = 7'h24;
      4'd3:  seg_o = 7'h30;
      4'd4:  seg_o = 7'h19;
      4'd5:  seg_o = 7'h12;
      4'd6:  seg_o = 7'h02;
      4'd7:  seg_o = 7'h78;
      4'd8:  seg_o = 7'h00;
      4'd9:  seg_o = 7'h10;
`ifdef DEBOUNCE_BCD7_HEX_EN
      4'd10: seg_o = 7'h08;
      4'd11: seg_o = 7'h03;
      4'd12: seg_o = 7'h46;
      4'd13: seg_o = 7'h21;
      4'd14: seg_o = 7'h06;
      4'd15: seg_o = 7'h0E;
`else
      default: seg_o = 7'h7F;
`endif
    endcase
  end

endmodule

// File: tb/tb_debounce_bcd7.sv
// Directed bench for debounce_bcd7 with a short stability window (4 cycles).
// Honours DEBOUNCE_BCD7_HEX_EN for the expected glyphs of codes 10..15.
module tb_debounce_bcd7;

  logic       clk;
  logic       rst_n;
  logic       key_i;
  logic       key_o;
  logic       key_rise;
  logic [3:0] bcd_i;
  logic [6:0] seg_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] seg_tab [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10,
`ifdef DEBOUNCE_BCD7_HEX_EN
    7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
`else
    7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
`endif
  };

  debounce_bcd7 #(.STABLE_CYCLES(4), .CNT_WIDTH(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_i    (key_i),
    .key_o    (key_o),
    .key_rise (key_rise),
    .bcd_i    (bcd_i),
    .seg_o    (seg_o)
  );

  // clock block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs and samples happen 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_key(input string name, input logic exp_key, input logic exp_rise);
    n_checks++;
    if (key_o !== exp_key) begin
      n_fail++;
      $display("FAIL %s key_o got=%b exp=%b t=%0t", name, key_o, exp_key, $time);
    end
    n_checks++;
    if (key_rise !== exp_rise) begin
      n_fail++;
      $display("FAIL %s key_rise got=%b exp=%b t=%0t", name, key_rise, exp_rise, $time);
    end
  endtask

  // Reset with key held, then release: key_o rises on the 6th edge, one strobe.
  task automatic test_reset();
    rst_n = 1'b0;
    key_i = 1'b1;
    bcd_i = 4'd8;
    #2;
    chk_key("reset_async", 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_key("reset_hold", 1'b0, 1'b0);
      n_checks++;
      if (seg_o !== 7'h00) begin
        n_fail++;
        $display("FAIL reset_seg seg_o got=%h exp=%h", seg_o, 7'h00);
      end
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step();
      chk_key("release_wait", 1'b0, 1'b0);
    end
    step();
    chk_key("release_rise", 1'b1, 1'b1);
    for (int e = 0; e < 4; e++) begin
      step();
      chk_key("held_one_pulse", 1'b1, 1'b0);
    end
  endtask

  // key_o=1, key_i drops: key_o falls on the 6th edge, never a strobe.
  task automatic test_release();
    key_i = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      step();
      chk_key("fall_wait", 1'b1, 1'b0);
    end
    step();
    chk_key("fall_done", 1'b0, 1'b0);
    step();
    chk_key("fall_after", 1'b0, 1'b0);
  endtask

  // A 3-cycle pulse is one cycle short of the window and must be filtered.
  task automatic test_short_pulse();
    key_i = 1'b1;
    for (int e = 0; e < 3; e++) begin
      step();
      chk_key("short_high", 1'b0, 1'b0);
    end
    key_i = 1'b0;
    for (int e = 0; e < 8; e++) begin
      step();
      chk_key("short_low", 1'b0, 1'b0);
    end
  endtask

  // Bounce 1,0,1,0 then steady 1: key_o rises 6 edges after the last rise.
  task automatic test_bounce();
    for (int b = 0; b < 4; b++) begin
      key_i = (b % 2 == 0) ? 1'b1 : 1'b0;
      step();
      chk_key("bounce", 1'b0, 1'b0);
    end
    key_i = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step();
      chk_key("bounce_wait", 1'b0, 1'b0);
    end
    step();
    chk_key("bounce_rise", 1'b1, 1'b1);
    for (int e = 0; e < 3; e++) begin
      step();
      chk_key("bounce_one_pulse", 1'b1, 1'b0);
    end
  endtask

  // Reset mid-count clears key_o at once and discards the pending transition.
  task automatic test_reset_mid_count();
    key_i = 1'b0;
    for (int e = 0; e < 3; e++) step();
    chk_key("mid_pre", 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_key("mid_async_clear", 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    key_i = 1'b1;
    for (int e = 0; e < 4; e++) step();
    chk_key("mid_pending", 1'b0, 1'b0);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step();
      chk_key("mid_restart_wait", 1'b0, 1'b0);
    end
    step();
    chk_key("mid_restart_rise", 1'b1, 1'b1);
    step();
    chk_key("mid_restart_after", 1'b1, 1'b0);
  endtask

  task automatic test_decode_bcd();
    for (int v = 0; v < 10; v++) begin
      bcd_i = 4'(v);
      #1;
      n_checks++;
      if (seg_o !== seg_tab[v]) begin
        n_fail++;
        $display("FAIL decode_bcd bcd=%0d seg_o got=%h exp=%h", v, seg_o, seg_tab[v]);
      end
    end
  endtask

  task automatic test_decode_high();
    for (int v = 10; v < 16; v++) begin
      bcd_i = 4'(v);
      #1;
      n_checks++;
      if (seg_o !== seg_tab[v]) begin
        n_fail++;
        $display("FAIL decode_high bcd=%0d seg_o got=%h exp=%h", v, seg_o, seg_tab[v]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    key_i = 1'b0;
    bcd_i = 4'd0;
    test_reset();
    test_release();
    test_short_pulse();
    test_bounce();
    test_reset_mid_count();
    test_decode_bcd();
    test_decode_high();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
